fifo_input_ctrl: RTL and testbench
==================================

FIFO_INPUT_CTRL -- requirements
Module: fifo_input_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 32, flit width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: DRTS  input  1  upstream request-to-send; Data_in valid while high.
REQ-005 Port: Data_in  input  DATA_WIDTH  incoming flit.
REQ-006 Port: read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  input  1 each  grants from the downstream output arbiters (Grant_* outputs).
REQ-007 Port: CTS  output  1  clear-to-send pulse back to upstream.
REQ-008 Port: Data_out  output  DATA_WIDTH  flit at head of FIFO.
REQ-009 Port: empty  output  1  FIFO holds no flits.
REQ-010 Port: full  output  1  FIFO holds 4 flits.
REQ-011 Port: err  output  1  sticky read-on-empty flag; present only with FIFO_ERR_EN.

Function
REQ-012 Storage SHALL be 4 entries of DATA_WIDTH, written by one-hot write pointer, read by one-hot read pointer, each 4 bits.
REQ-013 Occupancy SHALL be tracked by a 3-bit counter, range 0..4; empty = (count==0), full = (count==4), both combinational from the counter.
REQ-014 CTS SHALL be driven by register CTS_FF; CTS_FF_in = 1 iff DRTS=1, CTS_FF=0, full=0; otherwise 0.
REQ-015 A write SHALL occur in the cycle CTS_FF_in=1: Data_in stored at write pointer, write pointer rotates left by one (0001->0010->0100->1000->0001).
REQ-016 CTS SHALL therefore be high for exactly one cycle per accepted flit; a flit held with DRTS continuously high SHALL be accepted at most every second cycle.
REQ-017 read_en = (read_en_N|read_en_E|read_en_W|read_en_S|read_en_L) & ~empty; a read SHALL rotate the read pointer left by one.
REQ-018 Data_out SHALL be combinational: entry selected by read pointer, zero-latency; valid only when empty=0.
REQ-019 Simultaneous write and read SHALL leave count unchanged and advance both pointers.
REQ-020 Write when full SHALL be impossible (REQ-014); grant while empty SHALL not move the read pointer or count.
REQ-021 Pointer wrap from 1000 to 0001 SHALL occur without bubbles.
REQ-022 More than one read_en_* high in the same cycle SHALL be treated as one read.

Reset
REQ-023 On rst=1 at posedge: read and write pointers = 4'b0001, count = 0, CTS_FF = 0, err = 0; storage contents need not be cleared.
REQ-024 Reset SHALL override any concurrent write or read in that cycle; a flit in flight is discarded and upstream re-requests.
REQ-025 After reset: CTS=0, empty=1, full=0, Data_out = don't-care.

Configuration
REQ-026 Macro FIFO_ERR_EN: when defined, port err exists and sets (sticky until rst) in the cycle after any read_en_* is high while empty=1.
REQ-027 Without FIFO_ERR_EN: port err and its register are absent; all other behaviour identical.

Verification
REQ-028 Reset then idle: rst=1 one cycle -> CTS=0, empty=1, full=0, count=0 thereafter with DRTS=0.
REQ-029 Single flit: DRTS=1, Data_in=32'hA5A5_0001 -> CTS=1 next cycle, then 0; empty=0; Data_out=32'hA5A5_0001; read_en_E=1 one cycle -> empty=1.
REQ-030 Fill: 4 flits 32'h1..32'h4, no grants -> full=1 after 4th CTS; 5th DRTS held high -> CTS stays 0 until read_en_N=1, then one CTS and full=1 again.
REQ-031 Wrap and simultaneous: count=2, DRTS=1 with read_en_S=1 in the CTS-rising cycle -> count stays 2, flit order preserved across pointer wrap 1000->0001 over 10 flits 32'h10..32'h19.
REQ-032 Grant on empty: empty=1, read_en_L=1 -> pointers unchanged; with FIFO_ERR_EN err=1 next cycle and stays 1 until rst.
REQ-033 Mid-operation reset: count=3, rst=1 during CTS pulse -> next cycle count=0, CTS=0, empty=1, err=0.

Source files
------------

// File: rtl/fifo_input_ctrl.sv
// 4-deep input FIFO with CTS/DRTS handshake; zero-latency head read, one flit per two cycles on input.
// Optional sticky read-on-empty error flag under macro FIFO_ERR_EN.
module fifo_input_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DRTS,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
`ifdef FIFO_ERR_EN
  output logic                  err,
`endif
  output logic                  full
);

  logic [DATA_WIDTH-1:0] r_mem [4];
  logic [3:0]            r_wr_ptr;
  logic [3:0]            r_rd_ptr;
  logic [2:0]            r_count;
  logic                  r_cts_ff;

  logic w_cts_ff_in;
  logic w_grant;
  logic w_read_en;

  assign empty       = (r_count == 3'd0);
  assign full        = (r_count == 3'd4);
  assign CTS         = r_cts_ff;
  // CTS_FF toggles back to 0 after each accept, so a held DRTS is taken every other cycle
  assign w_cts_ff_in = DRTS & ~r_cts_ff & ~full;
  assign w_grant     = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  assign w_read_en   = w_grant & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 4'b0001;
      r_rd_ptr <= 4'b0001;
      r_count  <= 3'd0;
      r_cts_ff <= 1'b0;
    end else begin
      r_cts_ff <= w_cts_ff_in;
      if (w_cts_ff_in) begin
        r_wr_ptr <= {r_wr_ptr[2:0], r_wr_ptr[3]};
      end
      if (w_read_en) begin
        r_rd_ptr <= {r_rd_ptr[2:0], r_rd_ptr[3]};
      end
      if (w_cts_ff_in && !w_read_en) begin
        r_count <= r_count + 3'd1;
      end else if (!w_cts_ff_in && w_read_en) begin
        r_count <= r_count - 3'd1;
      end
    end
  end

  // Storage is not cleared on reset; gating with rst keeps a discarded flit out of the array
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && w_cts_ff_in && r_wr_ptr[i]) begin
        r_mem[i] <= Data_in;
      end
    end
  end

  always_comb begin
    Data_out = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_rd_ptr[i]) begin
        Data_out = r_mem[i];
      end
    end
  end

`ifdef FIFO_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_grant && empty) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_fifo_input_ctrl.sv
// Directed bench for fifo_input_ctrl: vector table plus hand sequences for wrap and mid-operation reset.
module tb_fifo_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        DRTS;
  logic [31:0] Data_in;
  logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic        CTS;
  logic [31:0] Data_out;
  logic        empty;
  logic        full;
`ifdef FIFO_ERR_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_input_ctrl #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .DRTS      (DRTS),
    .Data_in   (Data_in),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .CTS       (CTS),
    .Data_out  (Data_out),
    .empty     (empty),
`ifdef FIFO_ERR_EN
    .err       (err),
`endif
    .full      (full)
  );

  typedef struct {
    logic        rst;
    logic        drts;
    logic [31:0] din;
    logic [4:0]  gnt;   // {N,E,W,S,L}
    logic        cts;
    logic        emp;
    logic        ful;
    logic        chk_d;
    logic [31:0] dout;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic d, logic [31:0] di, logic [4:0] g,
                              logic c, logic e, logic f, logic cd, logic [31:0] dout);
    vec_t v;
    v.rst = r; v.drts = d; v.din = di; v.gnt = g;
    v.cts = c; v.emp = e; v.ful = f; v.chk_d = cd; v.dout = dout;
    return v;
  endfunction

  task automatic drive(logic r, logic d, logic [31:0] di, logic [4:0] g);
    rst = r; DRTS = d; Data_in = di;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = g;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] q[$];
  logic [31:0] head;

  initial begin
    drive(1'b1, 1'b0, 32'h0, 5'b0);

    // Expectations are the outputs just after the clock edge that consumed the inputs.
    tv.push_back(mk(1,0,32'h0,       5'b00000, 0,1,0,0,32'h0));
    tv.push_back(mk(0,0,32'h0,       5'b00000, 0,1,0,0,32'h0));
    tv.push_back(mk(0,1,32'hA5A50001,5'b00000, 1,0,0,1,32'hA5A50001));
    tv.push_back(mk(0,0,32'h0,       5'b00000, 0,0,0,1,32'hA5A50001));
    tv.push_back(mk(0,0,32'h0,       5'b01000, 0,1,0,0,32'h0));
    tv.push_back(mk(0,0,32'h0,       5'b00000, 0,1,0,0,32'h0));
    tv.push_back(mk(0,1,32'h1,       5'b00000, 1,0,0,1,32'h1));
    tv.push_back(mk(0,1,32'h2,       5'b00000, 0,0,0,1,32'h1));
    tv.push_back(mk(0,1,32'h2,       5'b00000, 1,0,0,1,32'h1));
    tv.push_back(mk(0,1,32'h3,       5'b00000, 0,0,0,1,32'h1));
    tv.push_back(mk(0,1,32'h3,       5'b00000, 1,0,0,1,32'h1));
    tv.push_back(mk(0,1,32'h4,       5'b00000, 0,0,0,1,32'h1));
    tv.push_back(mk(0,1,32'h4,       5'b00000, 1,0,1,1,32'h1));
    tv.push_back(mk(0,1,32'h5,       5'b00000, 0,0,1,1,32'h1));
    tv.push_back(mk(0,1,32'h5,       5'b00000, 0,0,1,1,32'h1));
    tv.push_back(mk(0,1,32'h5,       5'b10000, 0,0,0,1,32'h2));
    tv.push_back(mk(0,1,32'h5,       5'b00000, 1,0,1,1,32'h2));
    tv.push_back(mk(0,0,32'h0,       5'b00000, 0,0,1,1,32'h2));
    tv.push_back(mk(0,0,32'h0,       5'b11111, 0,0,0,1,32'h3));
    tv.push_back(mk(0,0,32'h0,       5'b00110, 0,0,0,1,32'h4));
    tv.push_back(mk(0,0,32'h0,       5'b00001, 0,0,0,1,32'h5));
    tv.push_back(mk(0,0,32'h0,       5'b11000, 0,1,0,0,32'h0));
    tv.push_back(mk(0,0,32'h0,       5'b00001, 0,1,0,0,32'h0));
    tv.push_back(mk(0,1,32'hBEEF,    5'b00000, 1,0,0,1,32'hBEEF));
    tv.push_back(mk(0,0,32'h0,       5'b01000, 0,1,0,0,32'h0));

    @(negedge clk);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].drts, tv[i].din, tv[i].gnt);
      cyc();
      chk($sformatf("v%0d cts", i),   {31'b0, CTS},   {31'b0, tv[i].cts});
      chk($sformatf("v%0d empty", i), {31'b0, empty}, {31'b0, tv[i].emp});
      chk($sformatf("v%0d full", i),  {31'b0, full},  {31'b0, tv[i].ful});
      if (tv[i].chk_d) chk($sformatf("v%0d dout", i), Data_out, tv[i].dout);
    end
`ifdef FIFO_ERR_EN
    chk("err after empty grant", {31'b0, err}, 32'd1);
`endif

    // Simultaneous write+read at count 2 across pointer wrap, flits 0x10..0x19.
    for (int d = 32'h10; d <= 32'h11; d++) begin
      drive(0, 1, d, 5'b0); cyc();
      chk("prefill cts", {31'b0, CTS}, 32'd1);
      q.push_back(d);
      drive(0, 0, 32'h0, 5'b0); cyc();
    end
    for (int d = 32'h12; d <= 32'h19; d++) begin
      drive(0, 1, d, 5'b00010);
      head = q.pop_front();
      chk("wrap head", Data_out, head);
      cyc();
      q.push_back(d);
      chk("wrap cts",   {31'b0, CTS},   32'd1);
      chk("wrap empty", {31'b0, empty}, 32'd0);
      chk("wrap full",  {31'b0, full},  32'd0);
      drive(0, 0, 32'h0, 5'b0); cyc();
      chk("wrap cts low", {31'b0, CTS}, 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 32'h0, 5'b10000);
      head = q.pop_front();
      chk("drain head", Data_out, head);
      cyc();
    end
    chk("drain empty", {31'b0, empty}, 32'd1);

    // Reset during a CTS pulse with count 3.
    for (int d = 32'h20; d <= 32'h22; d++) begin
      drive(0, 1, d, 5'b0); cyc();
      if (d != 32'h22) begin
        drive(0, 0, 32'h0, 5'b0); cyc();
      end
    end
    chk("pre-reset cts", {31'b0, CTS}, 32'd1);
    drive(1, 1, 32'h23, 5'b10000); cyc();
    chk("midrst cts",   {31'b0, CTS},   32'd0);
    chk("midrst empty", {31'b0, empty}, 32'd1);
    chk("midrst full",  {31'b0, full},  32'd0);
`ifdef FIFO_ERR_EN
    chk("midrst err", {31'b0, err}, 32'd0);
`endif
    // Reset must also swallow a write that would otherwise be accepted.
    drive(1, 1, 32'h24, 5'b0); cyc();
    chk("rst vs write cts",   {31'b0, CTS},   32'd0);
    chk("rst vs write empty", {31'b0, empty}, 32'd1);
    drive(0, 0, 32'h0, 5'b0); cyc();
    chk("post-rst idle empty", {31'b0, empty}, 32'd1);
    chk("post-rst idle cts",   {31'b0, CTS},   32'd0);

`ifdef FIFO_ERR_EN
    drive(0, 0, 32'h0, 5'b00001); cyc();
    chk("err set", {31'b0, err}, 32'd1);
    drive(0, 1, 32'h30, 5'b0); cyc();
    drive(0, 0, 32'h0, 5'b01000); cyc();
    chk("err sticky", {31'b0, err}, 32'd1);
    drive(1, 0, 32'h0, 5'b0); cyc();
    chk("err cleared", {31'b0, err}, 32'd0);
    drive(0, 0, 32'h0, 5'b0); cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
